// File: rtl/bif_bus_slave_resp.sv
// ND-100 BIF bus slave responder: synchronizes BDAP_n, decodes the address window,
// forwards hits to a local request port and completes the BDRY_n handshake.
module bif_bus_slave_resp #(
    parameter logic [23:0] BASE        = 24'h000000,
    parameter int          SIZE_LOG2   = 12,
    parameter int          IOSPACE     = 0,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                 sysclk,
    input  logic                 sys_rst,
    input  logic                 BDAP_n,
    input  logic                 BINPUT_n,
    input  logic                 BIORQ_n,
    input  logic [23:0]          BA,
    input  logic [15:0]          BD_IN,
    output logic                 BDRY_n,
    output logic [15:0]          BD_OUT,
    output logic                 BDOE,
    output logic                 LREQ,
    output logic                 LWRITE,
    output logic [SIZE_LOG2-1:0] LADDR,
    output logic [15:0]          LWDATA,
    input  logic                 LACK,
    input  logic [15:0]          LRDATA
);

    localparam logic [23:0] WIN_MASK = ~((24'd1 << SIZE_LOG2) - 24'd1);
    localparam logic [3:0]  WAIT_L   = 4'(WAIT_CYCLES);
    localparam logic        IO_N_HIT = (IOSPACE == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_IGNORE,
        S_LOCAL,
        S_WAIT,
        S_READY,
        S_RELEASE
    } state_e;

    state_e state_q, state_d;

    logic sync1_q, sync2_q;
    logic bdap_s;
    logic [1:0] settle_q;
    logic armed_q;

    logic [23:0] ba_q;
    logic [15:0] bdin_q;
    logic        binput_q;
    logic        biorq_q;
    logic        capture;
    logic        hit;

    logic [3:0]  cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic [15:0] rdata_q, rdata_d;

    logic                 bdry_n_q, bdry_n_d;
    logic                 bdoe_q, bdoe_d;
    logic [15:0]          bd_out_q, bd_out_d;
    logic                 lreq_q, lreq_d;
    logic                 lwrite_q, lwrite_d;
    logic [SIZE_LOG2-1:0] laddr_q, laddr_d;
    logic [15:0]          lwdata_q, lwdata_d;

    assign bdap_s = sync2_q;
    assign hit    = (biorq_q == IO_N_HIT) &&
                    ((ba_q & WIN_MASK) == (BASE & WIN_MASK));

    // A cycle is only accepted once the strobe has been seen high after reset,
    // so a master still holding BDAP_n low across reset gets no response.
    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q <= BDAP_n;
            sync2_q <= sync1_q;
            if (settle_q != 2'd2)
                settle_q <= settle_q + 2'd1;
            armed_q <= armed_q | ((settle_q == 2'd2) & bdap_s);
        end
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            ba_q     <= '0;
            bdin_q   <= '0;
            binput_q <= 1'b1;
            biorq_q  <= 1'b1;
        end else if (capture) begin
            ba_q     <= BA;
            bdin_q   <= BD_IN;
            binput_q <= BINPUT_n;
            biorq_q  <= BIORQ_n;
        end
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            rdata_q  <= '0;
            bdry_n_q <= 1'b1;
            bdoe_q   <= 1'b0;
            bd_out_q <= '0;
            lreq_q   <= 1'b0;
            lwrite_q <= 1'b0;
            laddr_q  <= '0;
            lwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            rdata_q  <= rdata_d;
            bdry_n_q <= bdry_n_d;
            bdoe_q   <= bdoe_d;
            bd_out_q <= bd_out_d;
            lreq_q   <= lreq_d;
            lwrite_q <= lwrite_d;
            laddr_q  <= laddr_d;
            lwdata_q <= lwdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        rdata_d  = rdata_q;
        lreq_d   = lreq_q;
        lwrite_d = lwrite_q;
        laddr_d  = laddr_q;
        lwdata_d = lwdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (armed_q && !bdap_s) begin
                    state_d = S_DECODE;
                    capture = 1'b1;
                end
            end
            S_DECODE: begin
                if (bdap_s) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    state_d  = S_LOCAL;
                    lreq_d   = 1'b1;
                    lwrite_d = binput_q;
                    laddr_d  = ba_q[SIZE_LOG2-1:0];
                    lwdata_d = bdin_q;
                    abort_d  = 1'b0;
                end else begin
                    state_d = S_IGNORE;
                end
            end
            S_IGNORE: begin
                if (bdap_s)
                    state_d = S_IDLE;
            end
            // The local side always sees its transaction through, even after
            // the master has given up; the abort is only honoured at LACK.
            S_LOCAL: begin
                if (bdap_s)
                    abort_d = 1'b1;
                if (LACK) begin
                    lreq_d = 1'b0;
                    cnt_d  = WAIT_L;
                    if (!lwrite_q)
                        rdata_d = LRDATA;
                    if (abort_q || bdap_s)
                        state_d = S_IDLE;
                    else if (WAIT_CYCLES > 0)
                        state_d = S_WAIT;
                    else
                        state_d = S_READY;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (bdap_s)
                    state_d = S_IDLE;
                else if (cnt_q <= 4'd1)
                    state_d = S_READY;
            end
            S_READY: begin
                if (bdap_s)
                    state_d = S_RELEASE;
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus-side outputs are registered straight from the next state so they
    // change on the same edge as the FSM.
    always_comb begin
        bdry_n_d = (state_d != S_READY);
        bdoe_d   = (state_d == S_READY) && !lwrite_q;
        bd_out_d = bd_out_q;
        if ((state_d == S_READY) && (state_q != S_READY) && !lwrite_q)
            bd_out_d = (state_q == S_LOCAL) ? LRDATA : rdata_q;
    end

    assign BDRY_n = bdry_n_q;
    assign BDOE   = bdoe_q;
    assign BD_OUT = bd_out_q;
    assign LREQ   = lreq_q;
    assign LWRITE = lwrite_q;
    assign LADDR  = laddr_q;
    assign LWDATA = lwdata_q;

endmodule

// File: tb/tb_bif_bus_slave_resp.sv
// Bench for bif_bus_slave_resp: two responders (WAIT_CYCLES 2 and 0) on one bus,
// directed and random cycles checked against a transaction-level model.
module tb_bif_bus_slave_resp;

    localparam logic [23:0] BASE = 24'h000000;
    localparam int SZ = 12;
    localparam int IOSP = 0;
    localparam int WC0 = 2;
    localparam int WC1 = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        bdap_n, binput_n, biorq_n;
    logic [23:0] ba;
    logic [15:0] bd_in, lrdata;
    logic [1:0]  bdry_n, bdoe, lreq, lwrite;
    logic [1:0]  lack = 2'b00;
    logic [15:0] bd_out[2];
    logic [15:0] lwdata[2];
    logic [11:0] laddr[2];

    int n_chk = 0;
    int n_err = 0;
    int lack_dly = 0;
    int rcnt[2] = '{0, 0};
    int wcs[2] = '{WC0, WC1};

    bif_bus_slave_resp #(.BASE(BASE), .SIZE_LOG2(SZ), .IOSPACE(IOSP),
                         .WAIT_CYCLES(WC0)) u_w2 (
        .sysclk(clk), .sys_rst(rst), .BDAP_n(bdap_n), .BINPUT_n(binput_n),
        .BIORQ_n(biorq_n), .BA(ba), .BD_IN(bd_in), .BDRY_n(bdry_n[0]),
        .BD_OUT(bd_out[0]), .BDOE(bdoe[0]), .LREQ(lreq[0]),
        .LWRITE(lwrite[0]), .LADDR(laddr[0]), .LWDATA(lwdata[0]),
        .LACK(lack[0]), .LRDATA(lrdata)
    );

    bif_bus_slave_resp #(.BASE(BASE), .SIZE_LOG2(SZ), .IOSPACE(IOSP),
                         .WAIT_CYCLES(WC1)) u_w0 (
        .sysclk(clk), .sys_rst(rst), .BDAP_n(bdap_n), .BINPUT_n(binput_n),
        .BIORQ_n(biorq_n), .BA(ba), .BD_IN(bd_in), .BDRY_n(bdry_n[1]),
        .BD_OUT(bd_out[1]), .BDOE(bdoe[1]), .LREQ(lreq[1]),
        .LWRITE(lwrite[1]), .LADDR(laddr[1]), .LWDATA(lwdata[1]),
        .LACK(lack[1]), .LRDATA(lrdata)
    );

    // local memory model: acknowledge lack_dly cycles after LREQ is first seen
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (lreq[i] && !lack[i]) begin
                if (rcnt[i] == lack_dly) lack[i] = 1'b1;
                else rcnt[i]++;
            end else begin
                lack[i] = 1'b0;
                rcnt[i] = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [23:0] a, input bit io);
        return ((a >> SZ) == (BASE >> SZ)) && (int'(io) == IOSP);
    endfunction

    int          fall_off[2], rel_off[2], lreq_n[2];
    bit          oe_seen[2], oe_bad[2], fchg[2], fset[2];
    logic [15:0] bd_rdy[2], wd_seen[2];
    logic [11:0] la_seen[2];
    logic        lw_seen[2];

    task automatic observe(input int off, input bit post);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!post && !bdry_n[i] && fall_off[i] < 0) fall_off[i] = off;
            if (post && bdry_n[i] && fall_off[i] >= 0 && rel_off[i] < 0)
                rel_off[i] = off;
            if (bdoe[i]) begin
                oe_seen[i] = 1'b1;
                bd_rdy[i] = bd_out[i];
                if (bdry_n[i]) oe_bad[i] = 1'b1;
            end
            if (lreq[i]) begin
                lreq_n[i]++;
                if (!fset[i]) begin
                    fset[i] = 1'b1;
                    la_seen[i] = laddr[i];
                    lw_seen[i] = lwrite[i];
                    wd_seen[i] = lwdata[i];
                end else if (la_seen[i] !== laddr[i] ||
                             lw_seen[i] !== lwrite[i] ||
                             wd_seen[i] !== lwdata[i]) begin
                    fchg[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic bus_cycle(input logic [23:0] a, input bit rd, input bit io,
                             input logic [15:0] wd, input int dly,
                             input logic [15:0] rdat, input bit abort);
        bit hit;
        int hold;
        int n;
        for (int i = 0; i < 2; i++) begin
            fall_off[i] = -1; rel_off[i] = -1; lreq_n[i] = 0;
            oe_seen[i] = 0; oe_bad[i] = 0; fchg[i] = 0; fset[i] = 0;
            bd_rdy[i] = 'x;
        end
        hit = model_hit(a, io);
        hold = abort ? 4 : (hit ? 40 : 8);
        @(negedge clk);
        ba = a; binput_n = !rd; biorq_n = !io; bd_in = wd;
        lrdata = rdat; lack_dly = dly; bdap_n = 1'b0;
        n = 0;
        while (n < hold) begin
            observe(n, 1'b0);
            n++;
            if (!abort && hit && fall_off[0] >= 0 && fall_off[1] >= 0) break;
        end
        @(negedge clk);
        bdap_n = 1'b1;
        for (int k = 0; k < 14; k++) observe(k, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("lreq_cycles[%0d]", i), lreq_n[i], hit ? dly + 1 : 0);
            chk($sformatf("bdry_fall[%0d]", i), fall_off[i],
                (hit && !abort) ? 4 + dly + wcs[i] : -1);
            chk($sformatf("bdoe_seen[%0d]", i), oe_seen[i], hit && rd && !abort);
            chk($sformatf("bdoe_no_rdy[%0d]", i), oe_bad[i], 0);
            chk($sformatf("idle_bdry[%0d]", i), bdry_n[i], 1);
            if (hit) begin
                chk($sformatf("laddr[%0d]", i), la_seen[i], a[SZ-1:0]);
                chk($sformatf("lwrite[%0d]", i), lw_seen[i], !rd);
                chk($sformatf("fields_stable[%0d]", i), fchg[i], 0);
                if (!rd) chk($sformatf("lwdata[%0d]", i), wd_seen[i], wd);
            end
            if (hit && rd && !abort)
                chk($sformatf("bd_out[%0d]", i), bd_rdy[i], rdat);
            if (hit && !abort)
                chk($sformatf("release[%0d]", i), rel_off[i], 2);
        end
    endtask

    initial begin
        int spur;
        int n;
        rst = 1'b1; bdap_n = 1'b1; binput_n = 1'b1; biorq_n = 1'b1;
        ba = '0; bd_in = '0; lrdata = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_bdry[%0d]", i), bdry_n[i], 1);
            chk($sformatf("rst_bdoe[%0d]", i), bdoe[i], 0);
            chk($sformatf("rst_bdout[%0d]", i), bd_out[i], 0);
            chk($sformatf("rst_lreq[%0d]", i), lreq[i], 0);
            chk($sformatf("rst_lwrite[%0d]", i), lwrite[i], 0);
            chk($sformatf("rst_laddr[%0d]", i), laddr[i], 0);
            chk($sformatf("rst_lwdata[%0d]", i), lwdata[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        bus_cycle(24'h000123, 1, 0, 16'h0000, 0, 16'hBEEF, 0);
        bus_cycle(24'h000FFF, 0, 0, 16'h1234, 1, 16'h0000, 0);
        bus_cycle(24'h001000, 1, 0, 16'h0000, 0, 16'h5555, 0);
        bus_cycle(24'h000040, 1, 1, 16'h0000, 0, 16'h6666, 0);
        bus_cycle(24'h000200, 1, 0, 16'h0000, 5, 16'hA5A5, 0);
        bus_cycle(24'h000300, 1, 0, 16'h0000, 7, 16'h1111, 1);
        bus_cycle(24'h000301, 1, 0, 16'h0000, 0, 16'h2222, 0);

        // reset while READY, master still holding the strobe low
        @(negedge clk);
        ba = 24'h000010; binput_n = 1'b0; biorq_n = 1'b1;
        lrdata = 16'hC0DE; lack_dly = 0; bdap_n = 1'b0;
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (!bdry_n[0]) break;
        end
        chk("rdy_before_rst", bdry_n[0], 0);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("async_bdry[%0d]", i), bdry_n[i], 1);
            chk($sformatf("async_bdoe[%0d]", i), bdoe[i], 0);
            chk($sformatf("async_bdout[%0d]", i), bd_out[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        spur = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                if (lreq[i] || !bdry_n[i]) spur++;
        end
        chk("no_resp_after_rst", spur, 0);
        @(negedge clk);
        bdap_n = 1'b1;
        repeat (5) @(negedge clk);
        bus_cycle(24'h000456, 1, 0, 16'h0000, 2, 16'h7E57, 0);

        for (int t = 0; t < 40; t++) begin
            logic [23:0] a;
            bit rd, io, ab;
            int dly;
            case ($urandom_range(0, 3))
                0: a = {12'h000, 12'($urandom)};
                1: a = 24'h000FFF;
                2: a = 24'h001000;
                default: a = 24'($urandom);
            endcase
            rd  = 1'($urandom_range(0, 1));
            io  = ($urandom_range(0, 4) == 0);
            ab  = ($urandom_range(0, 5) == 0);
            dly = ab ? $urandom_range(6, 9) : $urandom_range(0, 4);
            bus_cycle(a, rd, io, 16'($urandom), dly, 16'($urandom), ab);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
